column_selector: RTL and testbench

- Downstream consumer of the three debounced buttons (left, right, drop) in the Connect-4 game.
- Synchronizes the buttons to the game clock and detects rising edges.
- Maintains the cursor column with wrap-around.
- Issues one drop request per drop press to the board/game controller over a valid/ready handshake.
- Rejects drops into full columns with an error pulse.

---
 rtl/column_selector.sv | 148 ++++++++++++++
 tb/tb_column_selector.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/column_selector.sv
// ============================================================================
// Module      : column_selector
// Description : Connect-4 cursor column control. Synchronizes the left, right
//               and drop buttons and detects their rising edges. Moves the
//               cursor with wrap-around and issues drop requests over a
//               valid/ready handshake. Optional auto-repeat of held left/right
//               is enabled by defining COLUMN_SELECTOR_AUTO_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module column_selector #(
    parameter int          NUM_COLS     = 7,
    parameter int          COL_W        = 3,
    parameter int          START_COL    = 3,
    parameter logic [23:0] REPEAT_DELAY = 24'd5000000,
    parameter logic [23:0] REPEAT_RATE  = 24'd2000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                btn_left,
    input  logic                btn_right,
    input  logic                btn_drop,
    input  logic [NUM_COLS-1:0] col_full,
    input  logic                drop_ready,
    output logic [COL_W-1:0]    cursor_col,
    output logic                drop_valid,
    output logic [COL_W-1:0]    drop_col,
    output logic                err_full
);

    localparam logic [COL_W-1:0] c_LAST_COL  = COL_W'(NUM_COLS - 1);
    localparam logic [COL_W-1:0] c_START_COL = COL_W'(START_COL);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t           r_state;
    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [2:0]       r_prev;
    logic [COL_W-1:0] r_cursor;
    logic             r_drop_valid;
    logic [COL_W-1:0] r_drop_col;
    logic             r_err_full;

    logic [2:0]       w_press;
    logic             w_rep_fire;
    logic             w_move_left;
    logic             w_move_right;

    // Bit order in the button vectors: [0]=left, [1]=right, [2]=drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
            r_prev  <= 3'b000;
        end else begin
            r_sync1 <= {btn_drop, btn_right, btn_left};
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_press = r_sync2 & ~r_prev & {3{enable}};

`ifdef COLUMN_SELECTOR_AUTO_REPEAT_EN
    logic [23:0] r_rep_cnt;
    logic        r_rep_first;
    logic        w_hold;

    // Counter value equals the number of edges since the initial press.
    assign w_hold     = (r_state == IDLE) && enable && (r_sync2[0] ^ r_sync2[1]);
    assign w_rep_fire = w_hold &&
                        (r_rep_cnt == (r_rep_first ? REPEAT_DELAY : REPEAT_RATE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rep_cnt   <= 24'd0;
            r_rep_first <= 1'b1;
        end else if (!w_hold) begin
            r_rep_cnt   <= 24'd0;
            r_rep_first <= 1'b1;
        end else if (w_rep_fire) begin
            r_rep_cnt   <= 24'd1;
            r_rep_first <= 1'b0;
        end else begin
            r_rep_cnt   <= r_rep_cnt + 24'd1;
        end
    end
`else
    assign w_rep_fire = 1'b0;
`endif

    assign w_move_left  = (w_press[0] & ~w_press[1]) | (w_rep_fire & r_sync2[0]);
    assign w_move_right = (w_press[1] & ~w_press[0]) | (w_rep_fire & r_sync2[1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cursor     <= c_START_COL;
            r_drop_valid <= 1'b0;
            r_drop_col   <= '0;
            r_err_full   <= 1'b0;
        end else begin
            r_err_full <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A drop press wins over any simultaneous move.
                    if (w_press[2]) begin
                        if (col_full[r_cursor]) begin
                            r_err_full <= 1'b1;
                        end else begin
                            r_drop_col   <= r_cursor;
                            r_drop_valid <= 1'b1;
                            r_state      <= REQ;
                        end
                    end else if (w_move_left) begin
                        r_cursor <= (r_cursor == '0) ? c_LAST_COL : r_cursor - 1'b1;
                    end else if (w_move_right) begin
                        r_cursor <= (r_cursor == c_LAST_COL) ? '0 : r_cursor + 1'b1;
                    end
                end
                REQ: begin
                    if (drop_ready) begin
                        r_drop_valid <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_drop_valid <= 1'b0;
                end
            endcase
        end
    end

    assign cursor_col = r_cursor;
    assign drop_valid = r_drop_valid;
    assign drop_col   = r_drop_col;
    assign err_full   = r_err_full;

endmodule

`default_nettype wire

// File: tb/tb_column_selector.sv
// ============================================================================
// Module      : tb_column_selector
// Description : Self-checking bench for column_selector with a behavioural
//               model of cursor, drop request and full-column rejection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_column_selector;

    localparam int NUM_COLS = 7;
    localparam int COL_W    = 3;
    localparam int START    = 3;
    localparam int R_DELAY  = 10;
    localparam int R_RATE   = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                enable = 1'b0;
    logic                btn_left = 1'b0;
    logic                btn_right = 1'b0;
    logic                btn_drop = 1'b0;
    logic [NUM_COLS-1:0] col_full = '0;
    logic                drop_ready = 1'b0;
    logic [COL_W-1:0]    cursor_col;
    logic                drop_valid;
    logic [COL_W-1:0]    drop_col;
    logic                err_full;

    int total = 0;
    int bad   = 0;

    int m_cursor;
    int m_valid;
    int m_col;

    column_selector #(
        .NUM_COLS     (NUM_COLS),
        .COL_W        (COL_W),
        .START_COL    (START),
        .REPEAT_DELAY (24'(R_DELAY)),
        .REPEAT_RATE  (24'(R_RATE))
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_drop   (btn_drop),
        .col_full   (col_full),
        .drop_ready (drop_ready),
        .cursor_col (cursor_col),
        .drop_valid (drop_valid),
        .drop_col   (drop_col),
        .err_full   (err_full)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Moves produced by a single left/right hold whose synchronized level
    // stays high for `span` edges after the initial press edge.
    function automatic int moves_for_span(input int span);
`ifdef COLUMN_SELECTOR_AUTO_REPEAT_EN
        if (span >= R_DELAY) return 2 + (span - R_DELAY) / R_RATE;
        return 1;
`else
        return (span >= 0) ? 1 : 1;
`endif
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".cursor"}, int'(cursor_col), m_cursor);
        check({tag, ".valid"},  int'(drop_valid), m_valid);
        check({tag, ".col"},    int'(drop_col),   m_col);
    endtask

    // mask: [0]=left [1]=right [2]=drop, held for n clock cycles.
    task automatic do_press(input string tag, input logic [2:0] mask, input int n);
        int errs = 0;
        int exp_err = 0;
        int mv;
        btn_left  = mask[0];
        btn_right = mask[1];
        btn_drop  = mask[2];
        for (int i = 0; i < n; i++) begin
            tick();
            errs += int'(err_full);
        end
        btn_left  = 1'b0;
        btn_right = 1'b0;
        btn_drop  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            errs += int'(err_full);
        end
        if (enable && m_valid == 0) begin
            if (mask[2]) begin
                if (col_full[m_cursor]) exp_err = 1;
                else begin
                    m_valid = 1;
                    m_col   = m_cursor;
                end
            end else if (mask[1:0] == 2'b01) begin
                mv = moves_for_span(n - 1) % NUM_COLS;
                m_cursor = (m_cursor + NUM_COLS - mv) % NUM_COLS;
            end else if (mask[1:0] == 2'b10) begin
                mv = moves_for_span(n - 1);
                m_cursor = (m_cursor + mv) % NUM_COLS;
            end
        end
        check({tag, ".err_cycles"}, errs, exp_err);
        check_all(tag);
    endtask

    task automatic accept(input string tag, input int wait_cycles);
        int stable = 1;
        for (int i = 0; i < wait_cycles; i++) begin
            tick();
            if (drop_valid !== 1'b1 || int'(drop_col) != m_col) stable = 0;
        end
        check({tag, ".held"}, stable, 1);
        drop_ready = 1'b1;
        tick();
        drop_ready = 1'b0;
        m_valid = 0;
        check_all({tag, ".done"});
    endtask

    task automatic goto_col(input int col);
        for (int i = 0; i < NUM_COLS && m_cursor != col; i++)
            do_press("goto", 3'b010, 1);
    endtask

    initial begin
        m_cursor = START;
        m_valid  = 0;
        m_col    = 0;

        tick();
        tick();
        check("reset.err", int'(err_full), 0);
        check_all("reset");
        rst_n  = 1'b1;
        enable = 1'b1;
        tick();

        // Exact latency: rise before edge k, visible after edge k+2.
        btn_right = 1'b1;
        tick();
        check("lat.k", int'(cursor_col), 3);
        tick();
        check("lat.k1", int'(cursor_col), 3);
        tick();
        check("lat.k2", int'(cursor_col), 4);
        tick();
        tick();
        btn_right = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        m_cursor = 4;
        check_all("lat.after");

        goto_col(6);
        do_press("wrap_r", 3'b010, 2);
        check("wrap_r.zero", int'(cursor_col), 0);
        do_press("wrap_l", 3'b001, 2);
        check("wrap_l.six", int'(cursor_col), 6);
        goto_col(2);
        do_press("both", 3'b011, 3);

        goto_col(4);
        col_full = 7'b0000000;
        do_press("drop4", 3'b100, 2);
        do_press("ign_l", 3'b001, 2);
        do_press("ign_d", 3'b100, 2);
        accept("acc4", 10);

        goto_col(1);
        col_full = 7'b0000010;
        do_press("full1", 3'b100, 3);

        enable = 1'b0;
        do_press("dis_l", 3'b001, 2);
        do_press("dis_r", 3'b010, 2);
        do_press("dis_d", 3'b100, 2);
        btn_left = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        enable = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        btn_left = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check_all("no_replay");

        goto_col(0);
        do_press("repeat", 3'b010, 23);

        for (int it = 0; it < 30; it++) begin
            logic [2:0] op;
            col_full = NUM_COLS'($urandom);
            case ($urandom_range(0, 3))
                0:       op = 3'b001;
                1:       op = 3'b010;
                2:       op = 3'b011;
                default: op = 3'b100;
            endcase
            do_press("rnd", op, int'($urandom_range(1, 5)));
            if (m_valid != 0) accept("rnd_acc", int'($urandom_range(0, 6)));
        end

        goto_col(5);
        col_full = 7'b0000000;
        do_press("pre_rst", 3'b100, 2);
        #3;
        rst_n = 1'b0;
        #1;
        m_cursor = START;
        m_valid  = 0;
        m_col    = 0;
        check_all("async_rst");
        tick();
        rst_n = 1'b1;
        tick();
        check_all("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
